// File: rtl/tile_render_pkg.sv
// Shared lookup tables and geometry types for the tile board renderer.
// Cell values are exponents: e selects colour, decimal string and digit count.
package tile_render_pkg;

   localparam int unsigned GEOM_W = 11;
   typedef logic [GEOM_W-1:0] geom_t;
   typedef logic [2:0]        rgb_t;

   localparam rgb_t RGB_BLACK  = 3'b000;
   localparam rgb_t RGB_BORDER = 3'b010;
   localparam rgb_t RGB_ERROR  = 3'b100;

   localparam rgb_t COLOR_LUT [0:15] = '{
      3'b000, 3'b100, 3'b110, 3'b101, 3'b011, 3'b001, 3'b111, 3'b110,
      3'b110, 3'b110, 3'b110, 3'b110, 3'b000, 3'b000, 3'b000, 3'b000};

   // Decimal digits left-justified: digit 0 (most significant) sits in [15:12].
   localparam logic [15:0] BCD_LUT [0:15] = '{
      16'h0000, 16'h2000, 16'h4000, 16'h8000, 16'h1600, 16'h3200, 16'h6400, 16'h1280,
      16'h2560, 16'h5120, 16'h1024, 16'h2048, 16'h0000, 16'h0000, 16'h0000, 16'h0000};

   localparam logic [2:0] NDIGITS_LUT [0:15] = '{
      3'd1, 3'd1, 3'd1, 3'd1, 3'd2, 3'd2, 3'd2, 3'd3,
      3'd3, 3'd3, 3'd4, 3'd4, 3'd1, 3'd1, 3'd1, 3'd1};

   // Bit 6 = segment a ... bit 0 = segment g.
   localparam logic [6:0] SEG_MAP [0:9] = '{
      7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
      7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011};

   function automatic geom_t str_left(input int unsigned tile_px, input int unsigned digit_w,
                                      input int unsigned digit_gap, input logic [2:0] nd);
      int unsigned sw;
      sw = 32'(nd) * digit_w + (32'(nd) - 1) * digit_gap;
      return geom_t'((tile_px - sw) / 2);
   endfunction

endpackage

// File: rtl/tile_board_renderer_glyph.sv
// Combinational 7-segment glyph test; coordinates are relative to the glyph origin,
// so wrapped (negative) offsets fall outside the box automatically.
module seven_seg_glyph import tile_render_pkg::*; #(
   parameter int unsigned DIGIT_W = 20,
   parameter int unsigned DIGIT_H = 60,
   parameter int unsigned SEG_T   = 4
) (
   input  geom_t      lx,
   input  geom_t      ly,
   input  logic [3:0] digit,
   output logic       lit
);

   localparam int unsigned MID = DIGIT_H / 2;

   logic [6:0] segs;
   logic in_box, upper, lower, row_a, row_d, row_g, col_l, col_r;

   always_comb begin
      segs = '0;
      if (digit <= 4'd9) segs = SEG_MAP[digit];
      in_box = (lx < geom_t'(DIGIT_W)) && (ly < geom_t'(DIGIT_H));
      upper  = ly <= geom_t'(MID);
      lower  = ly >= geom_t'(MID);
      row_a  = ly < geom_t'(SEG_T);
      row_d  = ly >= geom_t'(DIGIT_H - SEG_T);
      row_g  = (ly >= geom_t'(MID - SEG_T / 2)) && (ly < geom_t'(MID - SEG_T / 2 + SEG_T));
      col_l  = lx < geom_t'(SEG_T);
      col_r  = lx >= geom_t'(DIGIT_W - SEG_T);
      lit    = in_box && ((segs[6] && row_a) ||
                          (segs[5] && col_r && upper) ||
                          (segs[4] && col_r && lower) ||
                          (segs[3] && row_d) ||
                          (segs[2] && col_l && lower) ||
                          (segs[1] && col_l && upper) ||
                          (segs[0] && row_g));
   end

endmodule

// File: rtl/tile_board_renderer.sv
// N x N tile board painter: per-frame board snapshot feeding a 3-stage
// clock-enabled pixel pipeline (locate -> fetch -> glyph/colour).
module tile_board_renderer import tile_render_pkg::*; #(
   parameter int unsigned GRID_N    = 4,
   parameter int unsigned CELL_W    = 4,
   parameter int unsigned MAX_EXP   = 11,
   parameter int unsigned TILE_PX   = 108,
   parameter int unsigned BORDER_PX = 8,
   parameter int unsigned DIGIT_W   = 20,
   parameter int unsigned DIGIT_H   = 60,
   parameter int unsigned SEG_T     = 4,
   parameter int unsigned DIGIT_GAP = 6
) (
   input  logic                              board_clk,
   input  logic                              reset,
   input  logic                              pix_ce,
   input  logic                              frame_start,
   input  logic [9:0]                        counter_x,
   input  logic [9:0]                        counter_y,
   input  logic                              in_display,
   input  logic [GRID_N*GRID_N*CELL_W-1:0]   board,
   input  logic                              board_valid,
   output logic                              vga_r,
   output logic                              vga_g,
   output logic                              vga_b,
   output logic                              snapshot_taken
);

   localparam int unsigned PITCH      = TILE_PX + BORDER_PX;
   localparam int unsigned GRID_EXT   = GRID_N * PITCH + BORDER_PX;
   localparam int unsigned IDX_W      = (GRID_N > 1) ? $clog2(GRID_N) : 1;
   localparam int unsigned BOARD_W    = GRID_N * GRID_N * CELL_W;
   localparam int unsigned DIGIT_STEP = DIGIT_W + DIGIT_GAP;
   localparam geom_t       GLYPH_TOP  = geom_t'((TILE_PX - DIGIT_H) / 2);

   logic [BOARD_W-1:0] shadow;
   logic               take;

   // S1 / S2 / S3 state
   geom_t              s1_x, s1_y;
   logic               s1_vis, s1_border;
   logic [IDX_W-1:0]   s1_col, s1_row;
   logic               s2_vis, s2_border;
   logic [CELL_W-1:0]  s2_e;
   geom_t              s2_lx, s2_ly;
   rgb_t               rgb;

   // combinational next-stage values
   geom_t              px, py, col_base, row_base;
   logic [IDX_W-1:0]   col_c, row_c;
   logic               vis_c, border_c;
   logic [CELL_W-1:0]  e_c;
   geom_t              lx_c, ly_c;
   logic [3:0]         e_idx;
   logic [2:0]         nd;
   geom_t              left, start, gx, gy;
   logic [3:0]         dig;
   logic               glyph_lit;
   rgb_t               rgb_c;

   assign take = pix_ce & frame_start & board_valid;

   always_ff @(posedge board_clk) begin
      if (reset) begin
         shadow         <= '0;
         snapshot_taken <= 1'b0;
      end else begin
         snapshot_taken <= take;
         if (take) shadow <= board;
      end
   end

   // Column/row by compare chain against k*PITCH; the last line belongs to no tile.
   always_comb begin
      px = geom_t'(counter_x);
      py = geom_t'(counter_y);
      col_c = '0;
      row_c = '0;
      col_base = '0;
      row_base = '0;
      for (int unsigned k = 1; k < GRID_N; k++) begin
         if (px >= geom_t'(k * PITCH)) begin
            col_c    = IDX_W'(k);
            col_base = geom_t'(k * PITCH);
         end
         if (py >= geom_t'(k * PITCH)) begin
            row_c    = IDX_W'(k);
            row_base = geom_t'(k * PITCH);
         end
      end
      border_c = ((px - col_base) < geom_t'(BORDER_PX)) || ((py - row_base) < geom_t'(BORDER_PX)) ||
                 (px >= geom_t'(GRID_N * PITCH)) || (py >= geom_t'(GRID_N * PITCH));
      vis_c    = in_display && (px < geom_t'(GRID_EXT)) && (py < geom_t'(GRID_EXT));
   end

   always_comb begin
      e_c  = shadow[(32'(s1_row) * GRID_N + 32'(s1_col)) * CELL_W +: CELL_W];
      lx_c = s1_x - geom_t'(32'(s1_col) * PITCH) - geom_t'(BORDER_PX);
      ly_c = s1_y - geom_t'(32'(s1_row) * PITCH) - geom_t'(BORDER_PX);
   end

   // Pick the one digit slot whose span holds lx; no match leaves gx out of range.
   always_comb begin
      e_idx = 4'(s2_e);
      nd    = NDIGITS_LUT[e_idx];
      left  = str_left(TILE_PX, DIGIT_W, DIGIT_GAP, nd);
      gy    = s2_ly - GLYPH_TOP;
      gx    = '1;
      dig   = '0;
      start = '0;
      for (int unsigned j = 0; j < 4; j++) begin
         start = left + geom_t'(j * DIGIT_STEP);
         if ((j < 32'(nd)) && ((s2_lx - start) < geom_t'(DIGIT_W))) begin
            gx  = s2_lx - start;
            dig = BCD_LUT[e_idx][(3 - j) * 4 +: 4];
         end
      end
   end

   seven_seg_glyph #(
      .DIGIT_W (DIGIT_W),
      .DIGIT_H (DIGIT_H),
      .SEG_T   (SEG_T)
   ) u_glyph (
      .lx    (gx),
      .ly    (gy),
      .digit (dig),
      .lit   (glyph_lit)
   );

   always_comb begin
      rgb_c = RGB_BLACK;
      if (!s2_vis)                         rgb_c = RGB_BLACK;
      else if (s2_border)                  rgb_c = RGB_BORDER;
      else if (s2_e == '0)                 rgb_c = RGB_BLACK;
      else if (s2_e > CELL_W'(MAX_EXP))    rgb_c = RGB_ERROR;
      else if (glyph_lit)                  rgb_c = COLOR_LUT[e_idx];
   end

   always_ff @(posedge board_clk) begin
      if (reset) begin
         s1_x <= '0; s1_y <= '0; s1_vis <= 1'b0; s1_border <= 1'b0;
         s1_col <= '0; s1_row <= '0;
         s2_vis <= 1'b0; s2_border <= 1'b0; s2_e <= '0; s2_lx <= '0; s2_ly <= '0;
         rgb <= RGB_BLACK;
      end else if (pix_ce) begin
         s1_x <= px; s1_y <= py; s1_vis <= vis_c; s1_border <= border_c;
         s1_col <= col_c; s1_row <= row_c;
         s2_vis <= s1_vis; s2_border <= s1_border; s2_e <= e_c; s2_lx <= lx_c; s2_ly <= ly_c;
         rgb <= rgb_c;
      end
   end

   assign vga_r = rgb[2];
   assign vga_g = rgb[1];
   assign vga_b = rgb[0];

endmodule

// File: tb/tb_tile_board_renderer.sv
// Bench for tile_board_renderer: directed vector table, reset/hold sequences,
// then random pixels against an arithmetic model of the board picture.
module tb_tile_board_renderer;

   localparam int PITCH = 116;
   localparam int EXT   = 4 * PITCH + 8;
   localparam logic [63:0] B1 = 64'h0000_0000_0000_0001;
   localparam logic [63:0] B2 = 64'hB000_0000_00D0_0000;

   logic board_clk = 1'b0;
   logic reset, pix_ce, frame_start, in_display, board_valid;
   logic [9:0] counter_x, counter_y;
   logic [63:0] board;
   logic vga_r, vga_g, vga_b, snapshot_taken;

   int checks = 0;
   int errors = 0;
   logic [63:0] m_shadow;
   logic [2:0]  expq[$];
   string       nameq[$];

   typedef struct packed {
      logic [63:0] brd;
      logic        fs, bv;
      logic [9:0]  x, y;
      logic        disp;
      logic [3:0]  idle;
      logic [2:0]  rgb;
   } vec_t;
   vec_t vecs[$];

   always #5 board_clk = ~board_clk;

   tile_board_renderer #(
      .GRID_N(4), .CELL_W(4), .MAX_EXP(11), .TILE_PX(108), .BORDER_PX(8),
      .DIGIT_W(20), .DIGIT_H(60), .SEG_T(4), .DIGIT_GAP(6)
   ) dut (
      .board_clk(board_clk), .reset(reset), .pix_ce(pix_ce), .frame_start(frame_start),
      .counter_x(counter_x), .counter_y(counter_y), .in_display(in_display),
      .board(board), .board_valid(board_valid),
      .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b), .snapshot_taken(snapshot_taken)
   );

   function automatic bit seg_on(int d, int s);
      case (s)
         0: return d inside {0, 2, 3, 5, 6, 7, 8, 9};
         1: return d inside {0, 1, 2, 3, 4, 7, 8, 9};
         2: return d inside {0, 1, 3, 4, 5, 6, 7, 8, 9};
         3: return d inside {0, 2, 3, 5, 6, 8, 9};
         4: return d inside {0, 2, 6, 8};
         5: return d inside {0, 4, 5, 6, 8, 9};
         default: return d inside {2, 3, 4, 5, 6, 8, 9};
      endcase
   endfunction

   function automatic bit glyph_px(int d, int gx, int gy);
      bit up, lo;
      if (gx < 0 || gx >= 20 || gy < 0 || gy >= 60) return 1'b0;
      up = gy <= 30;
      lo = gy >= 30;
      return (seg_on(d, 0) && gy < 4) || (seg_on(d, 1) && gx >= 16 && up) ||
             (seg_on(d, 2) && gx >= 16 && lo) || (seg_on(d, 3) && gy >= 56) ||
             (seg_on(d, 4) && gx < 4 && lo) || (seg_on(d, 5) && gx < 4 && up) ||
             (seg_on(d, 6) && gy >= 28 && gy < 32);
   endfunction

   function automatic logic [2:0] tile_colour(int e);
      case (e)
         1: return 3'b100;
         2: return 3'b110;
         3: return 3'b101;
         4: return 3'b011;
         5: return 3'b001;
         6: return 3'b111;
         default: return 3'b110;
      endcase
   endfunction

   function automatic logic [2:0] model_rgb(int x, int y, bit disp, logic [63:0] sh);
      int col, row, e, lx, ly, nd, sw, left, gy;
      string s;
      if (!disp || x >= EXT || y >= EXT) return 3'b000;
      if (x % PITCH < 8 || y % PITCH < 8) return 3'b010;
      col = x / PITCH;
      row = y / PITCH;
      e = int'(sh[(row * 4 + col) * 4 +: 4]);
      if (e == 0) return 3'b000;
      if (e > 11) return 3'b100;
      s = $sformatf("%0d", 1 << e);
      nd = s.len();
      sw = nd * 20 + (nd - 1) * 6;
      left = (108 - sw) / 2;
      lx = x % PITCH - 8;
      ly = y % PITCH - 8;
      gy = ly - 24;
      for (int j = 0; j < nd; j++)
         if (glyph_px(int'(s[j]) - 48, lx - (left + j * 26), gy)) return tile_colour(e);
      return 3'b000;
   endfunction

   task automatic check_rgb(input string name, input logic [2:0] want);
      checks++;
      if ({vga_r, vga_g, vga_b} !== want) begin
         errors++;
         $display("FAIL %s: rgb got %b want %b at %0t", name, {vga_r, vga_g, vga_b}, want, $time);
      end
   endtask

   task automatic check_snap(input string name, input logic want);
      checks++;
      if (snapshot_taken !== want) begin
         errors++;
         $display("FAIL %s: snapshot_taken got %b want %b at %0t", name, snapshot_taken, want, $time);
      end
   endtask

   // One pixel strobe, then idle cycles with pix_ce low; output is checked against
   // the pixel strobed two strobes earlier and must hold through the idle cycles.
   task automatic step(input logic [63:0] brd, input bit fs, input bit bv, input int x, input int y,
                       input bit disp, input int idle, input bit use_model, input logic [2:0] want,
                       input string name);
      logic [2:0] held;
      string      cur;
      if (fs && bv) m_shadow = brd;
      expq.push_back(use_model ? model_rgb(x, y, disp, m_shadow) : want);
      nameq.push_back(name);
      board = brd; frame_start = fs; board_valid = bv;
      counter_x = 10'(x); counter_y = 10'(y); in_display = disp; pix_ce = 1'b1;
      @(posedge board_clk); #1;
      held = expq.pop_front();
      cur  = nameq.pop_front();
      check_rgb(cur, held);
      check_snap({name, "_snap"}, fs && bv);
      pix_ce = 1'b0; frame_start = 1'b0;
      for (int i = 0; i < idle; i++) begin
         @(posedge board_clk); #1;
         check_rgb({cur, "_hold"}, held);
         check_snap({name, "_snap_hold"}, 1'b0);
      end
   endtask

   task automatic do_reset(input string name);
      reset = 1'b1; pix_ce = 1'b1; frame_start = 1'b1; board_valid = 1'b1; board = B2;
      counter_x = 10'd361; counter_y = 10'd380; in_display = 1'b1;
      @(posedge board_clk); #1;
      check_rgb({name, "_rgb"}, 3'b000);
      check_snap({name, "_snap"}, 1'b0);
      reset = 1'b0; pix_ce = 1'b0; frame_start = 1'b0;
      m_shadow = '0;
      expq  = '{3'b000, 3'b000};
      nameq = '{{name, "_pipe0"}, {name, "_pipe1"}};
   endtask

   function automatic void add(logic [63:0] b, bit fs, bit bv, int x, int y, bit d, int idle,
                               logic [2:0] r);
      vecs.push_back('{b, fs, bv, 10'(x), 10'(y), d, 4'(idle), r});
   endfunction

   initial begin
      logic [63:0] rb;
      bit          fs, bv;
      int          x, y;

      // empty board, extent and display gating
      add(64'h0, 1, 1,  50,  50, 1, 3, 3'b000);
      add(64'h0, 0, 0,   2,  50, 1, 3, 3'b010);
      add(64'h0, 0, 0, 600,  10, 1, 3, 3'b000);
      add(64'h0, 0, 0,  50,  50, 0, 3, 3'b000);
      add(64'h0, 0, 0,   2,  50, 0, 3, 3'b000);
      add(64'h0, 0, 0, 471,  10, 1, 3, 3'b010);
      add(64'h0, 0, 0, 472,  10, 1, 3, 3'b000);
      add(64'h0, 0, 0,  10, 471, 1, 3, 3'b010);
      add(64'h0, 0, 0,  10, 472, 1, 3, 3'b000);
      // cell 0 = "2"; long ce gap then back-to-back strobes
      add(B1, 1, 1,  62,  33, 1, 3, 3'b100);
      add(B1, 0, 0,  62,  62, 1, 5, 3'b100);
      add(B1, 0, 0,  54,  50, 1, 0, 3'b000);
      add(B1, 0, 0,  52,  32, 1, 0, 3'b100);
      add(B1, 0, 0,  71,  91, 1, 3, 3'b100);
      add(B1, 0, 0,  51,  32, 1, 3, 3'b000);
      add(B1, 0, 0,   8,   8, 1, 3, 3'b000);
      add(B1, 0, 0,   7,   8, 1, 3, 3'b010);
      // cell 15 = "2048", cell 5 = error exponent
      add(B2, 1, 1, 361, 380, 1, 3, 3'b110);
      add(B2, 0, 0, 387, 410, 1, 3, 3'b110);
      add(B2, 0, 0, 397, 410, 1, 3, 3'b000);
      add(B2, 0, 0, 420, 380, 1, 3, 3'b000);
      add(B2, 0, 0, 420, 410, 1, 3, 3'b110);
      add(B2, 0, 0, 448, 410, 1, 3, 3'b110);
      add(B2, 0, 0, 360, 380, 1, 3, 3'b000);
      add(B2, 0, 0, 124, 124, 1, 3, 3'b100);
      add(B2, 0, 0, 231, 231, 1, 3, 3'b100);
      add(B2, 0, 0, 232, 200, 1, 3, 3'b010);
      add(B2, 0, 0, 200, 120, 1, 3, 3'b010);
      // frame_start without board_valid keeps B2, next valid frame captures B1
      add(B1, 1, 0,  62,  33, 1, 3, 3'b000);
      add(B1, 0, 0, 361, 380, 1, 3, 3'b110);
      add(B1, 1, 1,  62,  33, 1, 3, 3'b100);
      add(B1, 0, 0, 361, 380, 1, 3, 3'b000);

      reset = 1'b1; pix_ce = 1'b0; frame_start = 1'b0; board_valid = 1'b0; board = '0;
      counter_x = '0; counter_y = '0; in_display = 1'b0;
      repeat (3) @(posedge board_clk);
      do_reset("init_reset");

      for (int i = 0; i < vecs.size(); i++)
         step(vecs[i].brd, vecs[i].fs, vecs[i].bv, int'(vecs[i].x), int'(vecs[i].y),
              vecs[i].disp, int'(vecs[i].idle), 1'b0, vecs[i].rgb, $sformatf("vec%0d", i));

      // reset while lit pixels are in flight, then empty board until next snapshot
      step(B2, 1, 1, 361, 380, 1, 1, 1'b0, 3'b110, "rs_lit0");
      step(B2, 0, 0, 420, 410, 1, 1, 1'b0, 3'b110, "rs_lit1");
      step(B2, 0, 0, 124, 124, 1, 1, 1'b0, 3'b100, "rs_lit2");
      do_reset("mid_reset");
      step(B2, 0, 0, 361, 380, 1, 3, 1'b0, 3'b000, "rs_empty0");
      step(B2, 0, 0, 124, 124, 1, 3, 1'b0, 3'b000, "rs_empty1");
      step(B2, 0, 0, 232, 200, 1, 3, 1'b0, 3'b010, "rs_border");
      step(B2, 1, 1, 361, 380, 1, 3, 1'b0, 3'b110, "rs_recap");

      // random frames and pixels against the model
      rb = '0;
      for (int i = 0; i < 600; i++) begin
         fs = (i % 60) == 0;
         bv = fs && ($urandom_range(0, 3) != 0);
         if (fs) for (int c = 0; c < 16; c++) rb[c * 4 +: 4] = 4'($urandom_range(0, 13));
         else rb = {$urandom, $urandom};
         if ($urandom_range(0, 1) == 1) begin
            x = $urandom_range(0, 3) * PITCH + 8 + $urandom_range(0, 107);
            y = $urandom_range(0, 3) * PITCH + 8 + $urandom_range(0, 107);
         end else begin
            x = $urandom_range(0, 639);
            y = $urandom_range(0, 479);
         end
         step(rb, fs, bv, x, y, $urandom_range(0, 7) != 0, $urandom_range(0, 3), 1'b1, 3'b000,
              $sformatf("rnd%0d_x%0d_y%0d", i, x, y));
      end
      step('0, 0, 0, 0, 0, 0, 2, 1'b0, 3'b000, "flush0");
      step('0, 0, 0, 0, 0, 0, 2, 1'b0, 3'b000, "flush1");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
